// File: rtl/bcd_to_binary_if.sv
// Request/response bundle for the BCD-to-binary converter.
// The master drives the BCD word and start strobe, and the slave returns the result flags.
interface bcd_to_binary_if #(
    parameter int DECIMAL_DIGITS = 4,
    parameter int OUTPUT_WIDTH   = 14
);
    logic [4*DECIMAL_DIGITS-1:0] i_BCD;
    logic                        i_Start;
    logic [OUTPUT_WIDTH-1:0]     o_Binary;
    logic                        o_DV;
    logic                        o_Busy;
    logic                        o_Error;
    logic                        o_Overflow;

    modport master (
        output i_BCD, i_Start,
        input  o_Binary, o_DV, o_Busy, o_Error, o_Overflow
    );

    modport slave (
        input  i_BCD, i_Start,
        output o_Binary, o_DV, o_Busy, o_Error, o_Overflow
    );
endinterface

// File: rtl/bcd_to_binary.sv
// Multicycle BCD-to-binary converter using reverse double-dabble.
// Each iteration shifts right once, then corrects one digit per cycle.
module bcd_to_binary #(
    parameter int DECIMAL_DIGITS = 4,
    parameter int OUTPUT_WIDTH   = 14
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    bcd_to_binary_if.slave   bus
);
    localparam int D  = DECIMAL_DIGITS;
    localparam int N  = OUTPUT_WIDTH;
    localparam int BW = 4 * D;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SHIFT,
        ADJUST,
        DONE
    } state_t;

    state_t          state;
    logic [BW-1:0]   r_bcd;
    logic [N-1:0]    r_bin;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   cnt;
    logic            err;

    logic            bad;
    logic [3:0]      cur;
    logic [3:0]      adj;
    logic [BW-1:0]   adjusted;
    logic [BW+N-1:0] shifted;

    // Digit validity, single-digit correction and the combined right shift.
    always_comb begin
        bad = 1'b0;
        for (int d = 0; d < D; d++) begin
            if (r_bcd[4*d +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        cur = r_bcd[{idx, 2'b00} +: 4];
        adj = (cur >= 4'd8) ? cur - 4'd3 : cur;
        adjusted = r_bcd;
        adjusted[{idx, 2'b00} +: 4] = adj;
        shifted = {r_bcd, r_bin} >> 1;
    end

    // Control FSM with registered outputs.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state          <= IDLE;
            r_bcd          <= '0;
            r_bin          <= '0;
            idx            <= '0;
            cnt            <= '0;
            err            <= 1'b0;
            bus.o_Binary   <= '0;
            bus.o_DV       <= 1'b0;
            bus.o_Busy     <= 1'b0;
            bus.o_Error    <= 1'b0;
            bus.o_Overflow <= 1'b0;
        end else begin
            bus.o_DV <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.i_Start) begin
                        r_bcd      <= bus.i_BCD;
                        r_bin      <= '0;
                        cnt        <= '0;
                        idx        <= '0;
                        err        <= 1'b0;
                        bus.o_Busy <= 1'b1;
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    // A bad digit is latched first and reported on the next cycle.
                    if (err) begin
                        state <= DONE;
                    end else if (bad) begin
                        err <= 1'b1;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= shifted;
                    idx            <= '0;
                    if (cnt == CW'(N - 1)) begin
                        state <= DONE;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= ADJUST;
                    end
                end
                ADJUST: begin
                    r_bcd <= adjusted;
                    if (idx == IW'(D - 1)) begin
                        state <= SHIFT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    bus.o_DV       <= 1'b1;
                    bus.o_Error    <= err;
                    bus.o_Overflow <= (r_bcd != '0) && !err;
                    bus.o_Binary   <= err ? '0 : r_bin;
                    bus.o_Busy     <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_to_binary.sv
// Scoreboard bench for bcd_to_binary: default (4 digits, 14 bits) and small
// (3 digits, 8 bits) instances share clock and reset.
module tb_bcd_to_binary;
    localparam int LA = 14 + 13 * 4 + 2;
    localparam int LB = 8 + 7 * 3 + 2;

    typedef struct {
        logic [31:0] bin;
        logic        err;
        logic        ovf;
        int          k;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt = 0;
    exp_t qa[$];
    exp_t qb[$];

    bcd_to_binary_if #(.DECIMAL_DIGITS(4), .OUTPUT_WIDTH(14)) ba ();
    bcd_to_binary_if #(.DECIMAL_DIGITS(3), .OUTPUT_WIDTH(8))  bb ();

    bcd_to_binary #(.DECIMAL_DIGITS(4), .OUTPUT_WIDTH(14)) dut_a (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (ba)
    );

    bcd_to_binary #(.DECIMAL_DIGITS(3), .OUTPUT_WIDTH(8)) dut_b (
        .i_Clock (clk),
        .i_Reset (rst),
        .bus     (bb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) if (ba.o_Busy) busy_cnt++;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor for the default instance.
    always @(negedge clk) begin
        if (ba.o_DV) begin
            if (qa.size() == 0) begin
                check("a_unexpected_dv", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_bin", 64'(ba.o_Binary), 64'(e.bin));
                check("a_err", 64'(ba.o_Error), 64'(e.err));
                check("a_ovf", 64'(ba.o_Overflow), 64'(e.ovf));
                check("a_lat", 64'(cyc - e.k), 64'(e.lat));
            end
        end
    end

    // Monitor for the small instance.
    always @(negedge clk) begin
        if (bb.o_DV) begin
            if (qb.size() == 0) begin
                check("b_unexpected_dv", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_bin", 64'(bb.o_Binary), 64'(e.bin));
                check("b_err", 64'(bb.o_Error), 64'(e.err));
                check("b_ovf", 64'(bb.o_Overflow), 64'(e.ovf));
                check("b_lat", 64'(cyc - e.k), 64'(e.lat));
            end
        end
    end

    // Called at a negedge with the target idle; pulses start for one edge.
    task automatic issue(input bit b, input logic [31:0] bcd,
                         input logic [31:0] bin, input bit err, input bit ovf);
        exp_t e;
        e.bin = bin;
        e.err = err;
        e.ovf = ovf;
        e.k   = cyc + 1;
        if (!b) begin
            e.lat = err ? 3 : LA;
            qa.push_back(e);
            ba.i_BCD   = bcd[15:0];
            ba.i_Start = 1'b1;
        end else begin
            e.lat = err ? 3 : LB;
            qb.push_back(e);
            bb.i_BCD   = bcd[11:0];
            bb.i_Start = 1'b1;
        end
        @(negedge clk);
        ba.i_Start = 1'b0;
        bb.i_Start = 1'b0;
        ba.i_BCD   = '1;
        bb.i_BCD   = '1;
    endtask

    task automatic wait_empty(input bit b);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = b ? (qb.size() == 0) : (qa.size() == 0);
        end
        if (!done) begin
            check(b ? "b_timeout" : "a_timeout", 64'd1, 64'd0);
            if (b) qb.delete(); else qa.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int k0;
        ba.i_BCD   = '0;
        ba.i_Start = 1'b0;
        bb.i_BCD   = '0;
        bb.i_Start = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_a", 64'({ba.o_Binary, ba.o_DV, ba.o_Busy, ba.o_Error, ba.o_Overflow}), 64'd0);
        check("reset_b", 64'({bb.o_Binary, bb.o_DV, bb.o_Busy, bb.o_Error, bb.o_Overflow}), 64'd0);
        @(negedge clk);

        busy_cnt = 0;
        issue(0, 32'h9999, 32'h270F, 0, 0);
        wait_empty(0);
        check("busy_cycles", 64'(busy_cnt), 64'd68);

        issue(0, 32'h1234, 32'h04D2, 0, 0);
        wait_empty(0);
        issue(0, 32'h0000, 32'h0000, 0, 0);
        repeat (10) @(negedge clk);
        check("bin_hold", 64'(ba.o_Binary), 64'h04D2);
        wait_empty(0);

        issue(0, 32'h12A4, 32'h0, 1, 0);
        wait_empty(0);
        repeat (5) @(negedge clk);
        check("err_hold", 64'(ba.o_Error), 64'd1);
        issue(0, 32'h0042, 32'd42, 0, 0);
        wait_empty(0);

        issue(1, 32'h255, 32'hFF, 0, 0);
        wait_empty(1);
        issue(1, 32'h256, 32'h00, 0, 1);
        wait_empty(1);
        issue(1, 32'h999, 32'hE7, 0, 1);
        wait_empty(1);
        issue(1, 32'h9A0, 32'h00, 1, 0);
        wait_empty(1);

        issue(0, 32'h1234, 32'h04D2, 0, 0);
        repeat (10) @(negedge clk);
        ba.i_BCD   = 16'h0777;
        ba.i_Start = 1'b1;
        @(negedge clk);
        ba.i_Start = 1'b0;
        wait_empty(0);
        repeat (80) @(negedge clk);

        ba.i_BCD   = 16'h0042;
        ba.i_Start = 1'b1;
        k0 = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            e.bin = 32'd42;
            e.err = 1'b0;
            e.ovf = 1'b0;
            e.k   = k0 + i * (LA + 1);
            e.lat = LA;
            qa.push_back(e);
        end
        for (int i = 0; i < 400 && cyc < k0 + 2 * (LA + 1); i++) @(negedge clk);
        ba.i_Start = 1'b0;
        wait_empty(0);

        issue(0, 32'h5678, 32'h0, 0, 0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        qa.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_out", 64'({ba.o_Binary, ba.o_DV, ba.o_Busy, ba.o_Error, ba.o_Overflow}), 64'd0);
        repeat (80) @(negedge clk);
        issue(0, 32'h8765, 32'h223D, 0, 0);
        wait_empty(0);

        check("qa_empty", 64'(qa.size()), 64'd0);
        check("qb_empty", 64'(qb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
